sprite_reader: RTL and testbench

SPRITE_READER -- requirements
Module: sprite_reader

---
 rtl/sprite_pkg.sv | 18 +
 rtl/sprite_reader_if.sv | 23 ++
 rtl/sprite_skid_fifo.sv | 44 ++++
 rtl/sprite_reader.sv | 145 ++++++++++++++
 tb/tb_sprite_reader.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/sprite_pkg.sv
// Shared constants and state encoding for the sprite reader and its pixel stream interface.
package sprite_pkg;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 24;
  localparam int XY_W   = 5;

  localparam int                DEF_SPRITE_W        = 30;
  localparam int                DEF_SPRITE_H        = 29;
  localparam logic [DATA_W-1:0] DEF_TRANSPARENT_KEY = 24'hFF00FF;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } state_t;

endpackage

// File: rtl/sprite_reader_if.sv
// Ready/valid pixel stream: the reader is the master, the pixel consumer is the slave.
interface sprite_reader_if;
  import sprite_pkg::*;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_pixel;
  logic              out_transparent;
  logic [XY_W-1:0]   out_x;
  logic [XY_W-1:0]   out_y;
  logic              out_last;

  modport master (
    output out_valid, out_pixel, out_transparent, out_x, out_y, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_pixel, out_transparent, out_x, out_y, out_last,
    output out_ready
  );

endinterface

// File: rtl/sprite_skid_fifo.sv
// Two-entry first-word-fall-through FIFO; an empty FIFO presents incoming data directly at its output.
module sprite_skid_fifo #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             push;
  logic             pop;

  // A word arriving into an empty FIFO while the consumer is ready bypasses storage entirely.
  assign push      = in_valid && !((count == 2'd0) && out_ready);
  assign pop       = out_ready && (count != 2'd0);
  assign out_valid = (count != 2'd0) || in_valid;
  assign out_data  = (count != 2'd0) ? mem[rd_ptr] : in_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  // NOTE: storage has no reset; count and pointers alone decide which words are meaningful.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/sprite_reader.sv
// Sprite walker: reads a SPRITE_W x SPRITE_H sprite from synchronous RAM and streams it as ready/valid pixels.
// Define SPRITE_READER_MIRROR_EN to honour the mirror input (horizontal flip); otherwise mirror is ignored.
module sprite_reader
  import sprite_pkg::*;
#(
  parameter int                SPRITE_W        = DEF_SPRITE_W,
  parameter int                SPRITE_H        = DEF_SPRITE_H,
  parameter logic [DATA_W-1:0] TRANSPARENT_KEY = DEF_TRANSPARENT_KEY
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              mirror,
  output logic [ADDR_W-1:0] read_address,
  input  logic [DATA_W-1:0] data_In,
  sprite_reader_if.master   stream,
  output logic              busy,
  output logic              done
);

`ifdef SPRITE_READER_MIRROR_EN
  localparam bit MIRROR_EN = 1'b1;
`else
  localparam bit MIRROR_EN = 1'b0;
`endif

  localparam logic [XY_W-1:0] X_MAX = XY_W'(SPRITE_W - 1);
  localparam logic [XY_W-1:0] Y_MAX = XY_W'(SPRITE_H - 1);

  state_t            state_q, state_d;
  logic [XY_W-1:0]   rd_x, rd_y;
  logic [XY_W-1:0]   beat_x, beat_y;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] col;
  logic              mirror_q;
  logic              rd_stage1, rd_stage2;
  logic [1:0]        fifo_count;
  logic              fifo_valid;
  logic [DATA_W-1:0] fifo_data;
  logic [2:0]        pending;
  logic              accept, issue, last_issue;
  logic              xfer, last_beat;

  // Reads owed to the FIFO: stored words plus both RAM pipeline stages, less the word leaving now.
  assign pending   = 3'(fifo_count) + 3'(rd_stage1) + 3'(rd_stage2) - 3'(xfer);
  assign col       = (mirror_q && MIRROR_EN) ? ADDR_W'(X_MAX - rd_x) : ADDR_W'(rd_x);
  assign xfer      = fifo_valid && stream.out_ready;
  assign last_beat = (beat_x == X_MAX) && (beat_y == Y_MAX);
  assign busy      = (state_q != IDLE) || done;

  always_comb begin
    // NOTE: every signal of this block gets a default first so no path can infer a latch.
    state_d    = state_q;
    accept     = 1'b0;
    issue      = 1'b0;
    last_issue = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: begin
        issue      = (pending < 3'd2);
        last_issue = issue && (rd_x == X_MAX) && (rd_y == Y_MAX);
        if (last_issue) state_d = DRAIN;
      end
      DRAIN: begin
        if (xfer && last_beat) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: all state updates are non-blocking so every register samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= IDLE;
      rd_x         <= '0;
      rd_y         <= '0;
      row_base     <= '0;
      mirror_q     <= 1'b0;
      read_address <= '0;
      rd_stage1    <= 1'b0;
      rd_stage2    <= 1'b0;
      beat_x       <= '0;
      beat_y       <= '0;
      done         <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_stage1 <= issue;
      rd_stage2 <= rd_stage1;
      done      <= xfer && last_beat;

      if (accept) begin
        row_base <= base_addr;
        mirror_q <= mirror;
        rd_x     <= '0;
        rd_y     <= '0;
      end else if (issue) begin
        read_address <= row_base + col;
        if (rd_x == X_MAX) begin
          rd_x     <= '0;
          rd_y     <= rd_y + XY_W'(1);
          row_base <= row_base + ADDR_W'(SPRITE_W);
        end else begin
          rd_x <= rd_x + XY_W'(1);
        end
      end

      // Screen-side position of the beat at the FIFO head, independent of mirroring.
      if (xfer) begin
        if (beat_x == X_MAX) begin
          beat_x <= '0;
          beat_y <= last_beat ? '0 : beat_y + XY_W'(1);
        end else begin
          beat_x <= beat_x + XY_W'(1);
        end
      end
    end
  end

  sprite_skid_fifo #(
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk       (Clk),
    .rst       (Reset),
    .in_valid  (rd_stage2),
    .in_data   (data_In),
    .out_ready (stream.out_ready),
    .out_valid (fifo_valid),
    .out_data  (fifo_data),
    .count     (fifo_count)
  );

  assign stream.out_valid       = fifo_valid;
  assign stream.out_pixel       = fifo_valid ? fifo_data : '0;
  assign stream.out_transparent = fifo_valid && (fifo_data == TRANSPARENT_KEY);
  assign stream.out_x           = beat_x;
  assign stream.out_y           = beat_y;
  assign stream.out_last        = fifo_valid && last_beat;

endmodule

// File: tb/tb_sprite_reader.sv
// Directed bench for sprite_reader: synchronous RAM model, beat-by-beat payload checks against a reference walk.
module tb_sprite_reader;

`ifdef SPRITE_READER_MIRROR_EN
  localparam bit MIR_ON = 1'b1;
`else
  localparam bit MIR_ON = 1'b0;
`endif

  localparam int          BEATS = 870;
  localparam logic [23:0] KEY   = 24'hFF00FF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        mirror = 1'b0;
  logic [14:0] base_addr = '0;
  logic [14:0] read_address;
  logic [23:0] data_in = '0;
  logic        busy;
  logic        done;
  bit          key_at5 = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          ntransp = 0;

  sprite_reader_if bus ();

  sprite_reader dut (
    .Clk          (clk),
    .Reset        (rst),
    .start        (start),
    .base_addr    (base_addr),
    .mirror       (mirror),
    .read_address (read_address),
    .data_In      (data_in),
    .stream       (bus),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] ram_val(input logic [14:0] a);
    return (key_at5 && a == 15'd5) ? KEY : {9'h15A, a};
  endfunction

  always @(posedge clk) data_in <= ram_val(read_address);

  function automatic logic [14:0] exp_addr(input logic [14:0] base, input logic mir, input int k);
    int x = k % 30;
    int y = k / 30;
    int c = (mir && MIR_ON) ? 29 - x : x;
    return 15'(int'(base) + y * 30 + c);
  endfunction

  function automatic logic [63:0] exp_beat(input logic [14:0] base, input logic mir, input int k);
    logic [23:0] p = ram_val(exp_addr(base, mir, k));
    return 64'({p, 5'(k % 30), 5'(k / 30), (k == BEATS - 1), (p == KEY)});
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check(tag, 64'({bus.out_valid, busy, done, bus.out_last, bus.out_transparent,
                    read_address, bus.out_pixel, bus.out_x, bus.out_y}), 64'd0);
  endtask

  // Entered at a negedge; start is driven immediately so a chained call lands in the done cycle.
  task automatic run_walk(input logic [14:0] base, input logic mir, input bit toggle,
                          input int reset_at, input bit chain);
    int k = 0;
    int cyc = 0;
    bit prev_stall = 1'b0;
    bit saw_done = 1'b0;
    ntransp = 0;
    base_addr = base;
    mirror = mir;
    start = 1'b1;
    while (k < BEATS) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (toggle && cyc == 50) begin
        start = 1'b1;
        base_addr = 15'h1234;
        mirror = ~mir;
      end
      if (reset_at >= 0 && k == reset_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("reset_mid_walk");
        repeat (6) begin
          @(negedge clk);
          saw_done |= done;
        end
        check("no_done_after_reset", 64'(saw_done), 64'd0);
        return;
      end
      if (cyc > 4000) begin
        check("walk_timeout", 64'(k), 64'(BEATS));
        return;
      end
      bus.out_ready = toggle ? cyc[0] : 1'b1;
      check("status_busy_done", 64'({busy, done}), 64'b10);
      if (!toggle) check("valid_timing", 64'(bus.out_valid), 64'(cyc >= 3));
      if (!toggle && cyc == 2) check("first_read_addr", 64'(read_address), 64'(exp_addr(base, mir, 0)));
      if (!toggle && cyc == 3) check("second_read_addr", 64'(read_address), 64'(exp_addr(base, mir, 1)));
      if (prev_stall) check("valid_hold", 64'(bus.out_valid), 64'd1);
      if (bus.out_valid) begin
        check("beat_payload", 64'({bus.out_pixel, bus.out_x, bus.out_y, bus.out_last, bus.out_transparent}),
              exp_beat(base, mir, k));
        if (bus.out_transparent && bus.out_ready) ntransp++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      if (bus.out_valid && bus.out_ready) k++;
    end
    @(negedge clk);
    check("done_cycle", 64'({busy, done, bus.out_valid}), 64'b110);
    if (!chain) begin
      @(negedge clk);
      check("idle_after_done", 64'({busy, done, bus.out_valid}), 64'b000);
    end
  endtask

  initial begin
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    rst = 1'b0;

    // Base 0 unmirrored, full rate, restarted in its own done cycle by a mirrored walk at base 100.
    run_walk(15'd0, 1'b0, 1'b0, -1, 1'b1);
    run_walk(15'd100, 1'b1, 1'b0, -1, 1'b0);

    // Consumer stalls every other cycle; a start request mid-walk must be ignored.
    run_walk(15'd200, 1'b1, 1'b1, -1, 1'b0);

    // Transparent key stored at address 5: only beat (5,0) is flagged.
    key_at5 = 1'b1;
    run_walk(15'd0, 1'b0, 1'b0, -1, 1'b0);
    check("transparent_count", 64'(ntransp), 64'd1);
    key_at5 = 1'b0;

    // Reset after 400 beats, then a full walk whose address wraps past 15'h7FFF.
    run_walk(15'd300, 1'b0, 1'b0, 400, 1'b0);
    run_walk(15'h7FFF, 1'b0, 1'b0, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
